// File: rtl/vga_stream_out.sv
// VGA output stage: raster timing generator, fixed-latency frame-buffer fetch,
// output-aligned RGB/HS/VS/DE with underflow detection and built-in test patterns.
module vga_stream_out #(
   parameter int DW       = 16,
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int RD_LAT   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [1:0]    test_mode,
   input  logic [DW-1:0] din,
   input  logic          din_vld,
   output logic          rd_req,
   output logic [DW-1:0] vga_rgb,
   output logic          vga_hsync,
   output logic          vga_vsync,
   output logic          vga_de,
   output logic          frame_start,
   output logic          underflow,
   output logic [15:0]   underflow_cnt
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int BW    = HW + 3;

   localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_ACT_N = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_ACT_N = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam logic HS_IDLE = ~HS_POL;
   localparam logic VS_IDLE = ~VS_POL;

   typedef enum logic {IDLE, RUN} state_t;

   // One slot of the alignment pipeline: everything the output stage needs
   // about the raster position that generated it.
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic       fs;
      logic [1:0] mode;
      logic [2:0] bar;
   } stage_t;

   localparam stage_t STAGE_IDLE = '{hs: HS_IDLE, vs: VS_IDLE, de: 1'b0, fs: 1'b0,
                                     mode: 2'd0, bar: 3'd0};

   state_t        state_q, state_d;
   logic [HW-1:0] h_q;
   logic [VW-1:0] v_q;
   logic [1:0]    mode_q;
   logic [1:0]    mode_eff;
   logic          run, frame_first, frame_last;
   logic          h_act, v_act, h_sync, v_sync;
   logic [BW-1:0] h_x8, bar_full;
   logic [2:0]    bar_raw;
   stage_t        raw;
   stage_t        pipe_q [RD_LAT];
   stage_t        last;
   logic [DW-1:0] pix_nxt;
   logic          uf_nxt;

   function automatic logic [DW-1:0] bar_colour(input logic [2:0] bar);
      logic [15:0]   c565;
      logic [23:0]   c888;
      logic [DW-1:0] colour;
      c565 = 16'h0000;
      c888 = 24'h000000;
      case (bar)
         3'd0:    begin c565 = 16'hFFFF; c888 = 24'hFFFFFF; end
         3'd1:    begin c565 = 16'hFFE0; c888 = 24'hFFFF00; end
         3'd2:    begin c565 = 16'h07FF; c888 = 24'h00FFFF; end
         3'd3:    begin c565 = 16'h07E0; c888 = 24'h00FF00; end
         3'd4:    begin c565 = 16'hF81F; c888 = 24'hFF00FF; end
         3'd5:    begin c565 = 16'hF800; c888 = 24'hFF0000; end
         3'd6:    begin c565 = 16'h001F; c888 = 24'h0000FF; end
         default: begin c565 = 16'h0000; c888 = 24'h000000; end
      endcase
      if (DW == 24) colour = DW'(c888);
      else          colour = DW'(c565);
      return colour;
   endfunction

   assign run         = (state_q == RUN);
   assign frame_first = (h_q == '0) && (v_q == '0);
   assign frame_last  = (h_q == H_LAST) && (v_q == V_LAST);
   assign h_act       = (h_q < H_ACT_N);
   assign v_act       = (v_q < V_ACT_N);
   assign h_sync      = (h_q >= HS_BEG) && (h_q <= HS_END);
   assign v_sync      = (v_q >= VS_BEG) && (v_q <= VS_END);

   // The mode register only loads at the end of the first cycle of a frame,
   // so that cycle must already see the incoming value.
   assign mode_eff = frame_first ? test_mode : mode_q;

   assign rd_req = run && (mode_eff == 2'd0) && h_act && v_act;

   assign h_x8     = {h_q, 3'b000};
   assign bar_full = h_x8 / BW'(H_ACTIVE);
   assign bar_raw  = bar_full[2:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every signal written in an always_comb block gets a default first,
   // otherwise a missed branch infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (frame_last && !enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q    <= '0;
         v_q    <= '0;
         mode_q <= 2'd0;
      end else if (run) begin
         if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + VW'(1);
         end else begin
            h_q <= h_q + HW'(1);
         end
         if (frame_first) mode_q <= test_mode;
      end else begin
         h_q <= '0;
         v_q <= '0;
      end
   end

   always_comb begin
      raw = STAGE_IDLE;
      if (run) begin
         raw.hs   = h_sync ? HS_POL : HS_IDLE;
         raw.vs   = v_sync ? VS_POL : VS_IDLE;
         raw.de   = h_act && v_act;
         raw.fs   = frame_first;
         raw.mode = mode_eff;
         raw.bar  = bar_raw;
      end
   end

   // NOTE: the delay line is reset, unlike a storage RAM, because its contents
   // drive the sync outputs directly and must come out of reset inactive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= STAGE_IDLE;
      end else begin
         pipe_q[0] <= raw;
         for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign last = pipe_q[RD_LAT-1];

   // Output stage lines up with din: a request made RD_LAT cycles ago is
   // answered in the same cycle its timing slot reaches the end of the pipe.
   always_comb begin
      pix_nxt = '0;
      uf_nxt  = 1'b0;
      if (last.de) begin
         case (last.mode)
            2'd0: begin
               if (din_vld) pix_nxt = din;
               else         uf_nxt  = 1'b1;
            end
            2'd1:    pix_nxt = bar_colour(last.bar);
            2'd2:    pix_nxt = '1;
            default: pix_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_rgb       <= '0;
         vga_hsync     <= HS_IDLE;
         vga_vsync     <= VS_IDLE;
         vga_de        <= 1'b0;
         frame_start   <= 1'b0;
         underflow     <= 1'b0;
         underflow_cnt <= 16'd0;
      end else begin
         vga_rgb     <= pix_nxt;
         vga_hsync   <= last.hs;
         vga_vsync   <= last.vs;
         vga_de      <= last.de;
         frame_start <= last.fs;
         underflow   <= uf_nxt;
         if (uf_nxt && (underflow_cnt != 16'hFFFF))
            underflow_cnt <= underflow_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vga_stream_out.sv
// Scoreboard bench for vga_stream_out on a tiny 16x8 raster: a reference raster
// model pushes expected outputs, a read model answers rd_req after RD_LAT cycles.
module tb_vga_stream_out;

   localparam int DW      = 16;
   localparam int H_ACT   = 8;
   localparam int H_TOT   = 16;
   localparam int HS_BEG  = 10;
   localparam int HS_END  = 12;
   localparam int V_ACT   = 4;
   localparam int V_TOT   = 8;
   localparam int VS_BEG  = 5;
   localparam int VS_END  = 6;
   localparam int LAT_OUT = 3;

   localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [1:0]    test_mode;
   logic [DW-1:0] din;
   logic          din_vld;
   logic          rd_req;
   logic [DW-1:0] vga_rgb;
   logic          vga_hsync, vga_vsync, vga_de, frame_start, underflow;
   logic [15:0]   underflow_cnt;

   vga_stream_out #(
      .DW(DW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(2)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .test_mode(test_mode),
      .din(din), .din_vld(din_vld), .rd_req(rd_req), .vga_rgb(vga_rgb),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
      .frame_start(frame_start), .underflow(underflow), .underflow_cnt(underflow_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          hs, vs, de, fs, uf;
      logic [DW-1:0] rgb;
   } exp_t;

   typedef struct packed {
      logic          req, vld;
      logic [DW-1:0] data;
   } rd_t;

   exp_t sb [$];
   rd_t  r1, r2;

   int         n_checks = 0;
   int         n_pass   = 0;
   bit         m_run;
   int         m_h, m_v, m_ucnt, line_cnt;
   logic [1:0] m_mode;
   bit         wh_en = 1'b0;
   int         cyc = 0;
   int         st_rd, st_hs, st_vs, st_fs, st_de, first_rd, first_de;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, got, exp);
      else             n_pass++;
   endtask

   function automatic exp_t idle_exp();
      exp_t e;
      e     = '0;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      return e;
   endfunction

   task automatic stats_clear();
      st_rd = 0; st_hs = 0; st_vs = 0; st_fs = 0; st_de = 0;
      first_rd = -1; first_de = -1;
   endtask

   // Reference raster: advance to the next cycle given the inputs just driven.
   task automatic model_advance(input logic en, input logic [1:0] mode);
      if (!m_run) begin
         if (en) begin m_run = 1'b1; m_h = 0; m_v = 0; m_mode = mode; end
      end else if (m_h == H_TOT-1 && m_v == V_TOT-1 && !en) begin
         m_run = 1'b0; m_h = 0; m_v = 0;
      end else begin
         if (m_h == H_TOT-1) begin
            m_h = 0;
            m_v = (m_v == V_TOT-1) ? 0 : m_v + 1;
         end else begin
            m_h++;
         end
         if (m_h == 0 && m_v == 0) m_mode = mode;
      end
   endtask

   task automatic step(input logic en, input logic [1:0] mode);
      exp_t e, raw;
      rd_t  cur;
      bit   act, hold;
      @(negedge clk);
      cyc++;
      check("rd_req", 32'(rd_req), 32'(m_run && m_mode == 2'd0 && m_h < H_ACT && m_v < V_ACT));

      e = sb.pop_front();
      if (e.uf) m_ucnt++;
      check("hsync", 32'(vga_hsync), 32'(e.hs));
      check("vsync", 32'(vga_vsync), 32'(e.vs));
      check("de", 32'(vga_de), 32'(e.de));
      check("rgb", 32'(vga_rgb), 32'(e.rgb));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("underflow", 32'(underflow), 32'(e.uf));
      check("underflow_cnt", 32'(underflow_cnt), 32'(m_ucnt));

      if (rd_req) st_rd++;
      if (!vga_hsync) st_hs++;
      if (!vga_vsync) st_vs++;
      if (frame_start) st_fs++;
      if (vga_de) st_de++;
      if (rd_req && first_rd < 0) first_rd = cyc;
      if (vga_de && first_de < 0) first_de = cyc;

      act  = m_run && m_h < H_ACT && m_v < V_ACT;
      hold = wh_en && act && m_mode == 2'd0 && m_h == 3 && m_v == 1;
      if (hold) wh_en = 1'b0;
      raw    = idle_exp();
      raw.hs = !(m_run && m_h >= HS_BEG && m_h <= HS_END);
      raw.vs = !(m_run && m_v >= VS_BEG && m_v <= VS_END);
      raw.de = act;
      raw.fs = m_run && m_h == 0 && m_v == 0;
      if (act) begin
         case (m_mode)
            2'd0: begin raw.rgb = hold ? '0 : DW'(m_h); raw.uf = hold; end
            2'd1: raw.rgb = BARS[m_h * 8 / H_ACT];
            2'd2: raw.rgb = '1;
            default: raw.rgb = '0;
         endcase
      end
      sb.push_back(raw);

      // Read model: pixel index within the line, answered RD_LAT cycles later;
      // din_vld toggles randomly when no answer is due.
      cur.req  = rd_req;
      cur.vld  = rd_req && !hold;
      cur.data = DW'(line_cnt);
      if (rd_req) line_cnt++;
      else        line_cnt = 0;
      din_vld = r2.req ? r2.vld : 1'($urandom_range(0, 1));
      din     = r2.vld ? r2.data : 16'hDEAD;
      r2 = r1;
      r1 = cur;

      enable    = en;
      test_mode = mode;
      model_advance(en, mode);
   endtask

   task automatic apply_reset(input logic en, input logic [1:0] mode);
      #2 rst = 1'b1;
      #1;
      check("rst_rd_req", 32'(rd_req), 32'd0);
      check("rst_de", 32'(vga_de), 32'd0);
      check("rst_hsync", 32'(vga_hsync), 32'd1);
      check("rst_vsync", 32'(vga_vsync), 32'd1);
      check("rst_rgb", 32'(vga_rgb), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
      check("rst_underflow_cnt", 32'(underflow_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m_run = 1'b0; m_h = 0; m_v = 0; m_mode = 2'd0; m_ucnt = 0; line_cnt = 0;
      r1 = '0; r2 = '0;
      sb.delete();
      for (int i = 0; i < LAT_OUT; i++) sb.push_back(idle_exp());
      din_vld   = 1'b0;
      din       = '0;
      enable    = en;
      test_mode = mode;
      model_advance(en, mode);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; test_mode = 2'd0; din = '0; din_vld = 1'b0;
      stats_clear();
      apply_reset(1'b0, 2'd0);
      repeat (5) step(1'b0, 2'd0);

      // Timing of the first frame, measured on the DUT outputs.
      step(1'b1, 2'd0);
      stats_clear();
      repeat (128) step(1'b1, 2'd0);
      check("rd_req_per_frame", 32'(st_rd), 32'd32);
      check("hsync_low_per_frame", 32'(st_hs), 32'd24);
      check("vsync_low_per_frame", 32'(st_vs), 32'd32);
      check("frame_start_per_frame", 32'(st_fs), 32'd1);
      check("first_de_latency", 32'(first_de - first_rd), 32'd3);

      repeat (128) step(1'b1, 2'd0);

      // One withheld pixel: line 1, pixel 3.
      wh_en = 1'b1;
      repeat (128) step(1'b1, 2'd0);
      check("underflow_cnt_after_gap", 32'(underflow_cnt), 32'd1);

      // Mode changes mid-frame take effect on the following frame.
      repeat (40) step(1'b1, 2'd0);
      repeat (88) step(1'b1, 2'd1);
      stats_clear();
      repeat (40) step(1'b1, 2'd1);
      check("bars_no_rd_req", 32'(st_rd), 32'd0);
      repeat (88) step(1'b1, 2'd2);
      repeat (40) step(1'b1, 2'd2);
      repeat (88) step(1'b1, 2'd3);
      repeat (40) step(1'b1, 2'd3);
      repeat (88) step(1'b1, 2'd0);

      // Drop enable at cycle 40, bounce it, drop again: frame completes, then idle.
      repeat (40) step(1'b1, 2'd0);
      repeat (20) step(1'b0, 2'd0);
      repeat (40) step(1'b1, 2'd0);
      repeat (28) step(1'b0, 2'd0);
      stats_clear();
      repeat (12) step(1'b0, 2'd0);
      check("idle_rd_req", 32'(st_rd), 32'd0);
      check("idle_de_after_flush", 32'(st_de), 32'd0);
      check("idle_hsync", 32'(vga_hsync), 32'd1);

      // Reset in the middle of an active line, then a clean restart.
      step(1'b1, 2'd0);
      repeat (20) step(1'b1, 2'd0);
      apply_reset(1'b1, 2'd0);
      stats_clear();
      repeat (128) step(1'b1, 2'd0);
      check("restart_frame_start", 32'(st_fs), 32'd1);
      check("restart_rd_req", 32'(st_rd), 32'd32);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
